fetch_unit: RTL and testbench

// - IF stage of the 5-stage MIPS pipeline: owns pcF and the IF/ID pipeline register, and drives decode.
// - Fetches over a req/ready/rvalid instruction-memory port with variable latency and one request in flight.
// - Consumes stallF/stallD from the hazard unit and branch redirects (pcsrcD/pcbranchD) from decode.
// - Emits instrD/pcplus4D/validD.

---
 rtl/fetch_unit_pkg.sv | 13 +
 rtl/fetch_unit_ifid_reg.sv | 43 ++++
 rtl/fetch_unit.sv | 126 ++++++++++++
 tb/tb_fetch_unit.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the MIPS fetch stage: FSM encoding, PC width, bubble word.
package fetch_unit_pkg;

  localparam int PC_W = 32;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_ifid_reg.sv
// Pipeline register holding instruction word, PC+4 and valid; clr loads a bubble
// (NOP word, valid=0) while keeping the PC field.
module ifid_reg #(
  parameter int          W   = 32,
  parameter logic [W-1:0] NOP = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic [W-1:0] instr_i,
  input  logic [W-1:0] pc_i,
  output logic [W-1:0] instr_o,
  output logic [W-1:0] pc_o,
  output logic         valid_o
);

  logic [W-1:0] instr_q;
  logic [W-1:0] pc_q;
  logic         valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q <= NOP;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else if (en_i) begin
      if (clr_i) begin
        instr_q <= NOP;
        valid_q <= 1'b0;
      end else begin
        instr_q <= instr_i;
        pc_q    <= pc_i;
        valid_q <= 1'b1;
      end
    end
  end

  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// IF stage: owns pcF, fetches over a single-outstanding req/ready/rvalid port,
// and feeds the IF/ID register with instructions or bubbles.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0]     NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stallF,
  input  logic            stallD,
  input  logic            pcsrcD,
  input  logic [PC_W-1:0] pcbranchD,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic [PC_W-1:0] pcF,
  output logic [31:0]     instrD,
  output logic [PC_W-1:0] pcplus4D,
  output logic            validD
);

  fetch_state_e    state_q, state_d;
  logic            drop_q, drop_d;
  logic [31:0]     hold_q, hold_d;
  logic [PC_W-1:0] pc_q, pc_d;

  logic            redirect;
  logic            accept;
  logic            deliver;
  logic [31:0]     deliver_word;
  logic [PC_W-1:0] pc_plus4;

  assign redirect = pcsrcD & ~stallD;
  assign pc_plus4 = pc_q + 32'd4;
  assign accept   = imem_req & imem_ready;

  always_comb begin
    state_d      = state_q;
    drop_d       = drop_q;
    hold_d       = hold_q;
    pc_d         = pc_q;
    deliver      = 1'b0;
    deliver_word = imem_rdata;
    imem_req     = 1'b0;

    case (state_q)
      S_REQ: begin
        imem_req = ~stallF & ~reset;
        if (accept) begin
          state_d = S_WAIT;
          if (redirect) drop_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else if (redirect) begin
            state_d = S_REQ;
          end else if (!stallD) begin
            deliver = 1'b1;
            pc_d    = pc_plus4;
            state_d = S_REQ;
          end else begin
            hold_d  = imem_rdata;
            state_d = S_HOLD;
          end
        end else if (redirect) begin
          drop_d = 1'b1;
        end
      end
      S_HOLD: begin
        deliver_word = hold_q;
        if (redirect) begin
          state_d = S_REQ;
        end else if (!stallD) begin
          deliver = 1'b1;
          pc_d    = pc_plus4;
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase

    // Redirect overrides both the sequential advance and stallF.
    if (redirect) pc_d = pcbranchD;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_REQ;
      drop_q  <= 1'b0;
      hold_q  <= '0;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      hold_q  <= hold_d;
      pc_q    <= pc_d;
    end
  end

  assign imem_addr = pc_q;
  assign pcF       = pc_q;

  ifid_reg #(
    .W   (32),
    .NOP (NOP_INSTR)
  ) u_ifid (
    .clk     (clk),
    .rst     (reset),
    .en_i    (~stallD),
    .clr_i   (~deliver),
    .instr_i (deliver_word),
    .pc_i    (pc_plus4),
    .instr_o (instrD),
    .pc_o    (pcplus4D),
    .valid_o (validD)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: the memory side is driven step by step.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stallF, stallD, pcsrcD;
  logic [31:0] pcbranchD;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready, imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] pcF, instrD, pcplus4D;
  logic        validD;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] WA = 32'hAAAA_0001;
  localparam logic [31:0] WB = 32'hBBBB_0002;
  localparam logic [31:0] WC = 32'hCCCC_0003;
  localparam logic [31:0] WD = 32'hDDDD_0004;
  localparam logic [31:0] WE = 32'hEEEE_0005;
  localparam logic [31:0] WF = 32'hFFFF_0006;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .stallF      (stallF),
    .stallD      (stallD),
    .pcsrcD      (pcsrcD),
    .pcbranchD   (pcbranchD),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .pcF         (pcF),
    .instrD      (instrD),
    .pcplus4D    (pcplus4D),
    .validD      (validD)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; stallF = 1'b0; stallD = 1'b0; pcsrcD = 1'b0;
    pcbranchD = 32'h0; imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    step(); step();
    chk("rst_pcF", pcF, 32'h0);
    chk("rst_validD", validD, 0);
    chk("rst_instrD", instrD, 32'h0);
    chk("rst_pcplus4D", pcplus4D, 32'h0);
    chk("rst_req", imem_req, 0);

    // back-to-back fetch, 1-cycle latency
    reset = 1'b0; #1;
    chk("t1_req0", imem_req, 1);
    chk("t1_addr0", imem_addr, 32'h0);
    step();
    imem_rvalid = 1'b1; imem_rdata = WA; #1;
    chk("t1_wait_noreq", imem_req, 0);
    step();
    imem_rvalid = 1'b0; #1;
    chk("t1_instrA", instrD, WA);
    chk("t1_pc4A", pcplus4D, 32'h4);
    chk("t1_validA", validD, 1);
    chk("t1_pcF4", pcF, 32'h4);
    chk("t1_req1", imem_req, 1);
    chk("t1_addr4", imem_addr, 32'h4);
    step();
    chk("t1_bubble_valid", validD, 0);
    chk("t1_bubble_pc4", pcplus4D, 32'h4);
    imem_rvalid = 1'b1; imem_rdata = WB;
    step();
    imem_rvalid = 1'b0;
    chk("t1_instrB", instrD, WB);
    chk("t1_pc4B", pcplus4D, 32'h8);
    chk("t1_validB", validD, 1);
    chk("t1_pcF8", pcF, 32'h8);

    // ready low for three cycles
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t2_req_held", imem_req, 1);
      chk("t2_addr_held", imem_addr, 32'h8);
      step();
      chk("t2_valid_low", validD, 0);
    end
    imem_ready = 1'b1; #1;
    step();
    chk("t2_accepted", imem_req, 0);
    imem_rvalid = 1'b1; imem_rdata = WC;
    step();
    imem_rvalid = 1'b0;
    chk("t2_instrC", instrD, WC);
    chk("t2_pc4C", pcplus4D, 32'hC);
    chk("t2_pcF", pcF, 32'hC);

    // stallD while the response arrives
    stallD = 1'b1;
    step();
    chk("t3_hold_instr0", instrD, WC);
    imem_rvalid = 1'b1; imem_rdata = WD;
    step();
    imem_rvalid = 1'b0;
    chk("t3_hold_instr1", instrD, WC);
    chk("t3_hold_valid1", validD, 1);
    chk("t3_hold_pcF1", pcF, 32'hC);
    step();
    chk("t3_hold_instr2", instrD, WC);
    chk("t3_hold_pc42", pcplus4D, 32'hC);
    stallD = 1'b0;
    step();
    chk("t3_instrD", instrD, WD);
    chk("t3_pc4D", pcplus4D, 32'h10);
    chk("t3_validD", validD, 1);
    chk("t3_pcF", pcF, 32'h10);

    // redirect while waiting; late response must be dropped
    step();
    pcsrcD = 1'b1; pcbranchD = 32'h100;
    step();
    pcsrcD = 1'b0;
    chk("t4_pcF_redir", pcF, 32'h100);
    chk("t4_valid_bub", validD, 0);
    chk("t4_wait_noreq", imem_req, 0);
    imem_rvalid = 1'b1; imem_rdata = WE;
    step();
    imem_rvalid = 1'b0; #1;
    chk("t4_dropped_valid", validD, 0);
    chk("t4_dropped_instr", instrD, 32'h0);
    chk("t4_req", imem_req, 1);
    chk("t4_addr", imem_addr, 32'h100);
    step();
    imem_rvalid = 1'b1; imem_rdata = WF;
    step();
    imem_rvalid = 1'b0;
    chk("t4_instrF", instrD, WF);
    chk("t4_pc4F", pcplus4D, 32'h104);
    chk("t4_pcF", pcF, 32'h104);

    // pcsrcD masked by stallD, plus stallF in S_REQ
    stallF = 1'b1; stallD = 1'b1; pcsrcD = 1'b1; pcbranchD = 32'h200; #1;
    chk("t5_noreq", imem_req, 0);
    step();
    chk("t5_pcF_kept", pcF, 32'h104);
    chk("t5_instr_kept", instrD, WF);
    stallD = 1'b0; pcsrcD = 1'b0;
    step();
    chk("t6_pcF_const", pcF, 32'h104);
    chk("t6_noreq", imem_req, 0);
    chk("t6_bubble", validD, 0);
    stallF = 1'b0; #1;
    chk("t6_req_resume", imem_req, 1);
    chk("t6_addr_resume", imem_addr, 32'h104);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
